// File: rtl/act_bit_packer.sv
// act_bit_packer: gathers 1-bit binarized activations into WORD_W-bit words
// (LSB first), tags each word with a feature-map address and an end-of-frame
// flag, and streams them out through a small valid/ready word FIFO.
module act_bit_packer #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  frame_bits,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf_err,
    output logic              seq_err
);

    localparam int unsigned POS_W = $clog2(WORD_W);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_len;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  word_addr;
    logic [WORD_W-1:0]  shift_reg;

    // FIFO storage; the head entry is mirrored into the out_* registers
    logic [WORD_W-1:0]     mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]     mem_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;

    logic [POS_W-1:0]  pos;
    logic              bit_acc;
    logic              final_bit;
    logic              word_done;
    logic [WORD_W-1:0] word_nxt;
    logic              pop;
    logic              fifo_full;
    logic              push_ok;
    logic              push_drop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [OCC_W-1:0]  occ_after_pop;
    logic [OCC_W-1:0]  occ_nxt;
    logic              start_ok;
    logic              start_bad;
    logic              stray_bit;

    // Bit acceptance, word completion and the word being assembled
    always_comb begin
        pos       = bit_cnt[POS_W-1:0];
        bit_acc   = (state == PACK) && bit_valid;
        final_bit = bit_acc && (bit_cnt == frame_len - CNT_W'(1));
        word_done = bit_acc && ((pos == POS_W'(WORD_W - 1)) || final_bit);
        word_nxt  = shift_reg | (WORD_W'(bit_in) << pos);
    end

    // FIFO bookkeeping: a push into a full FIFO is kept only if the head pops now
    always_comb begin
        pop           = out_valid && out_ready;
        fifo_full     = (occ == OCC_W'(FIFO_DEPTH));
        push_ok       = word_done && (!fifo_full || pop);
        push_drop     = word_done && fifo_full && !pop;
        wr_ptr        = rd_ptr + PTR_W'(occ);
        rd_ptr_nxt    = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        occ_after_pop = occ - OCC_W'(pop);
        occ_nxt       = occ_after_pop + OCC_W'(push_ok);
    end

    // Protocol misuse detection
    always_comb begin
        start_ok  = frame_start && (state == IDLE) && (frame_bits != '0);
        start_bad = frame_start && ((state != IDLE) || (frame_bits == '0));
        stray_bit = bit_valid && (state != PACK);
    end

    // Frame FSM plus bit counter, shift register and word address
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_len <= '0;
            bit_cnt   <= '0;
            word_addr <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= PACK;
                        busy      <= 1'b1;
                        frame_len <= frame_bits;
                        word_addr <= base_addr;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                PACK: begin
                    if (bit_acc) begin
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        shift_reg <= word_done ? '0 : word_nxt;
                        // address advances even for dropped words
                        if (word_done) begin
                            word_addr <= word_addr + ADDR_W'(1);
                        end
                        if (final_bit) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (occ == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage write and read pointer / occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
            mem_last <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push_ok) begin
                mem_data[wr_ptr] <= word_nxt;
                mem_addr[wr_ptr] <= word_addr;
                mem_last[wr_ptr] <= final_bit;
            end
            rd_ptr <= rd_ptr_nxt;
            occ    <= occ_nxt;
        end
    end

    // Registered head: the new word bypasses storage when nothing else is queued
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else if (occ_nxt == '0) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (occ_after_pop == '0) begin
                out_data <= word_nxt;
                out_addr <= word_addr;
                out_last <= final_bit;
            end else begin
                // slot rd_ptr_nxt is never the one written this cycle here
                out_data <= mem_data[rd_ptr_nxt];
                out_addr <= mem_addr[rd_ptr_nxt];
                out_last <= mem_last[rd_ptr_nxt];
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            if (push_drop) begin
                ovf_err <= 1'b1;
            end
            if (start_bad || stray_bit) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule
